// File: rtl/spart_pkg.sv
// Shared constants and types for the spart serial port: bus register map, FSM states,
// baud divisors for a 100 MHz clock at 16x oversampling, and the TX frame builder.
package spart_pkg;

   localparam logic [1:0] ADDR_BUF  = 2'b00;
   localparam logic [1:0] ADDR_STAT = 2'b01;
   localparam logic [1:0] ADDR_DBL  = 2'b10;
   localparam logic [1:0] ADDR_DBH  = 2'b11;

   localparam logic [15:0] DIV_4800  = 16'h0515;
   localparam logic [15:0] DIV_9600  = 16'h028A;
   localparam logic [15:0] DIV_19200 = 16'h0145;
   localparam logic [15:0] DIV_38400 = 16'h00A2;

   localparam int OSR_DEF = 16;

   typedef enum logic {
      TX_IDLE,
      TX_SHIFT
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // 8N1 frame, transmitted from bit 0 upward: start(0), data LSB first, stop(1).
   function automatic logic [9:0] tx_frame(input logic [7:0] data);
      return {1'b1, data, 1'b0};
   endfunction

endpackage

// File: rtl/spart_baud_gen.sv
// Programmable baud divisor and down-counter; en16 pulses one clk every divisor+1 clks.
// Divisor byte writes land next clk and only take effect at the following counter reload.
module spart_baud_gen
   import spart_pkg::*;
#(
   parameter logic [15:0] DEFAULT_DIV = DIV_4800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [7:0]  wdata,
   output logic [15:0] divisor,
   output logic        en16
);

   logic [15:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         divisor <= DEFAULT_DIV;
         cnt     <= DEFAULT_DIV;
      end else begin
         if (wr_lo) divisor[7:0]  <= wdata;
         if (wr_hi) divisor[15:8] <= wdata;
         if (cnt == 16'd0) cnt <= divisor;
         else              cnt <= cnt - 16'd1;
      end
   end

   assign en16 = (cnt == 16'd0);

endmodule

// File: rtl/spart.sv
// 8N1 UART on a simple chip-select bus; TX start bit within divisor+2 clks of the buffer write.
// Buffer writes while tbr=0 are dropped; unread RX bytes are overwritten by newer ones.
module spart
   import spart_pkg::*;
#(
   parameter logic [15:0] DEFAULT_DIV = DIV_4800,
   parameter int          OSR         = OSR_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   output logic       rda,
   output logic       tbr,
   output logic       txd,
   input  logic       rxd
);

   localparam int            CW       = $clog2(OSR);
   localparam logic [CW-1:0] OS_LAST  = CW'(OSR - 1);
   localparam logic [CW-1:0] OS_HALF  = CW'(OSR / 2 - 1);

   logic        wr, rd, wr_buf, rd_buf;
   logic [7:0]  wdata, rd_data, rx_buf;
   logic [15:0] divisor;
   logic        en16;

   assign wr     = iocs & ~iorw;
   assign rd     = iocs & iorw;
   assign wdata  = databus;
   assign wr_buf = wr && (ioaddr == ADDR_BUF);
   assign rd_buf = rd && (ioaddr == ADDR_BUF);

   spart_baud_gen #(.DEFAULT_DIV(DEFAULT_DIV)) u_baud (
      .clk     (clk),
      .rst     (rst),
      .wr_lo   (wr && (ioaddr == ADDR_DBL)),
      .wr_hi   (wr && (ioaddr == ADDR_DBH)),
      .wdata   (wdata),
      .divisor (divisor),
      .en16    (en16)
   );

   always_comb begin
      rd_data = 8'h00;
      case (ioaddr)
         ADDR_BUF:  rd_data = rx_buf;
         ADDR_STAT: rd_data = {6'b0, tbr, rda};
         ADDR_DBL:  rd_data = divisor[7:0];
         ADDR_DBH:  rd_data = divisor[15:8];
      endcase
   end

   assign databus = rd ? rd_data : 8'bz;

   // ---------------- transmitter ----------------
   tx_state_t      tx_state, tx_next;
   logic [9:0]     tx_sh;
   logic [CW-1:0]  tx_os;
   logic [3:0]     tx_bit;
   logic           tx_load, tx_done;

   // Bits go out on os==0 pulses; the 11th such pulse marks the end of the stop bit.
   always_comb begin
      tx_next = tx_state;
      tx_load = 1'b0;
      tx_done = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (wr_buf) begin
               tx_load = 1'b1;
               tx_next = TX_SHIFT;
            end
         end
         TX_SHIFT: begin
            if (en16 && tx_os == '0 && tx_bit == 4'd10) begin
               tx_done = 1'b1;
               tx_next = TX_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) tx_state <= TX_IDLE;
      else     tx_state <= tx_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_sh  <= '1;
         tx_os  <= '0;
         tx_bit <= '0;
         txd    <= 1'b1;
         tbr    <= 1'b1;
      end else if (tx_load) begin
         tx_sh  <= tx_frame(wdata);
         tx_os  <= '0;
         tx_bit <= '0;
         tbr    <= 1'b0;
      end else if (tx_done) begin
         tbr <= 1'b1;
      end else if (tx_state == TX_SHIFT && en16) begin
         tx_os <= (tx_os == OS_LAST) ? '0 : tx_os + CW'(1);
         if (tx_os == '0) begin
            txd    <= tx_sh[0];
            tx_sh  <= {1'b1, tx_sh[9:1]};
            tx_bit <= tx_bit + 4'd1;
         end
      end
   end

   // ---------------- receiver ----------------
   rx_state_t      rx_state, rx_next;
   logic [1:0]     rx_sync;
   logic           rx_s, rx_prev, rx_done;
   logic [CW-1:0]  rx_os;
   logic [2:0]     rx_bit;
   logic [7:0]     rx_sh;

   assign rx_s = rx_sync[1];

   always_comb begin
      rx_next = rx_state;
      rx_done = 1'b0;
      case (rx_state)
         RX_IDLE:  if (rx_prev && !rx_s) rx_next = RX_START;
         RX_START: if (en16 && rx_os == OS_HALF) rx_next = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (en16 && rx_os == OS_LAST && rx_bit == 3'd7) rx_next = RX_STOP;
         RX_STOP: begin
            if (en16 && rx_os == OS_LAST) begin
               rx_next = RX_IDLE;
               rx_done = rx_s;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) rx_state <= RX_IDLE;
      else     rx_state <= rx_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_sync <= 2'b11;
         rx_prev <= 1'b1;
         rx_os   <= '0;
         rx_bit  <= '0;
         rx_sh   <= '0;
         rx_buf  <= '0;
         rda     <= 1'b0;
      end else begin
         rx_sync <= {rx_sync[0], rxd};
         rx_prev <= rx_s;
         case (rx_state)
            RX_IDLE: begin
               rx_os  <= '0;
               rx_bit <= '0;
            end
            RX_START: begin
               if (en16) rx_os <= (rx_os == OS_HALF) ? '0 : rx_os + CW'(1);
            end
            RX_DATA, RX_STOP: begin
               if (en16) begin
                  rx_os <= (rx_os == OS_LAST) ? '0 : rx_os + CW'(1);
                  if (rx_state == RX_DATA && rx_os == OS_LAST) begin
                     rx_sh  <= {rx_s, rx_sh[7:1]};
                     rx_bit <= rx_bit + 3'd1;
                  end
               end
            end
         endcase
         // A completing frame wins over a same-cycle buffer read.
         if (rx_done) begin
            rx_buf <= rx_sh;
            rda    <= 1'b1;
         end else if (rd_buf) begin
            rda <= 1'b0;
         end
      end
   end

endmodule
